// File: rtl/disp_pkg.sv
// Shared definitions for the display bus: word width, opcode field values and arbiter FSM states.
package disp_pkg;

    localparam int unsigned WORD_W = 15;

    localparam logic [3:0] OP_X     = 4'b0000;
    localparam logic [3:0] OP_YMOVE = 4'b0010;
    localparam logic [3:0] OP_YDRAW = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    // Width of an index into n requesters, never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester after the last owner wins, one-hot result.
module rr_pick
    import disp_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant
);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last) + k) % NREQ;
            if (!found && req[IW'(idx)]) begin
                grant[IW'(idx)] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_bus_arbiter.sv
// Packet arbiter routing NREQ word-handshake sources onto one display port.
// Optional stall watchdog is enabled with the DISP_ARB_WATCHDOG_EN macro.
module display_bus_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned WD_LIMIT = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_ldav,
    input  logic [NREQ-1:0]          req_last,
    input  logic [WORD_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_lrfd,
    input  logic                     LRFD,
    output logic                     LDAV,
    output logic [WORD_W-1:0]        DATA,
    output logic [NREQ-1:0]          grant,
    output logic                     wd_err
);

    localparam int unsigned IW = idx_w(NREQ);

    if (NREQ < 2 || NREQ > 4 || WD_LIMIT < 1) begin : g_bad_param
        $error("display_bus_arbiter: NREQ must be 2..4 and WD_LIMIT at least 1");
    end

    arb_state_t          state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d, pick, route;
    logic [NREQ-1:0]     lrfd_q, lrfd_d;
    logic [IW-1:0]       last_owner_q, last_owner_d, own_idx;
    logic                ldav_q, ldav_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                sel_req, sel_ldav, sel_last;
    logic [WORD_W-1:0]   sel_data;
    logic                timeout;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req   (req),
        .last  (last_owner_q),
        .grant (pick)
    );

    // The owner being routed: the fresh pick while leaving ARB, otherwise the held grant.
    assign route = (state_q == ST_ARB) ? pick : grant_q;

    always_comb begin
        own_idx  = '0;
        sel_req  = 1'b0;
        sel_ldav = 1'b1;
        sel_last = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (route[i]) begin
                own_idx  = IW'(i);
                sel_req  = req[i];
                sel_ldav = req_ldav[i];
                sel_last = req_last[i];
                sel_data = req_data[i*WORD_W +: WORD_W];
            end
        end
    end

`ifdef DISP_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            lrfd_prev_q, ldav_prev_q, wd_err_q;
    logic            wd_edge_c;

    assign wd_edge_c = (LRFD != lrfd_prev_q) || (sel_ldav != ldav_prev_q);
    assign timeout   = (state_q == ST_XFER) && (wd_cnt_q == WD_W'(WD_LIMIT));
    assign wd_err    = wd_err_q;

    // Counts XFER cycles with no handshake movement on either side of the routed port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q    <= '0;
            lrfd_prev_q <= 1'b0;
            ldav_prev_q <= 1'b1;
            wd_err_q    <= 1'b0;
        end else begin
            lrfd_prev_q <= LRFD;
            ldav_prev_q <= sel_ldav;
            wd_err_q    <= timeout;
            if (state_q == ST_XFER && !wd_edge_c && !timeout) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end else begin
                wd_cnt_q <= '0;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign wd_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (|req) state_d = ST_ARB;
            ST_ARB:  state_d = (|pick) ? ST_XFER : ST_IDLE;
            ST_XFER: begin
                // A word in flight (source LDAV low) is always finished before leaving.
                if (timeout)                   state_d = ST_DONE;
                else if (last_q && sel_ldav)   state_d = ST_DONE;
                else if (!sel_req && sel_ldav) state_d = ST_DONE;
            end
            ST_DONE: state_d = (|req) ? ST_ARB : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values are decoded from the next state so the registers line up with it.
    always_comb begin
        grant_d      = '0;
        lrfd_d       = '1;
        ldav_d       = 1'b1;
        data_d       = data_q;
        last_d       = 1'b0;
        last_owner_d = last_owner_q;
        if (state_d == ST_XFER) begin
            grant_d          = route;
            lrfd_d[own_idx]  = LRFD;
            ldav_d           = sel_ldav;
            data_d           = sel_data;
            last_d           = (!ldav_q && LRFD) ? sel_last : last_q;
        end
        if (state_d == ST_DONE && state_q == ST_XFER) begin
            last_owner_d = own_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q      <= '0;
            lrfd_q       <= '1;
            ldav_q       <= 1'b1;
            data_q       <= '0;
            last_q       <= 1'b0;
            last_owner_q <= IW'(NREQ - 1);
        end else begin
            grant_q      <= grant_d;
            lrfd_q       <= lrfd_d;
            ldav_q       <= ldav_d;
            data_q       <= data_d;
            last_q       <= last_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign req_lrfd = lrfd_q;
    assign LDAV     = ldav_q;
    assign DATA     = data_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_display_bus_arbiter.sv
// Scoreboard bench for display_bus_arbiter: source/sink handshake models, round-robin reference.
module tb_display_bus_arbiter;
    import disp_pkg::*;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned WW    = 15;
    localparam int unsigned BOUND = 2000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           s_req  [NREQ];
    logic           s_ldav [NREQ];
    logic           s_last [NREQ];
    logic [WW-1:0]  s_data [NREQ];

    logic [NREQ-1:0]    req, req_ldav, req_last, req_lrfd, grant;
    logic [WW*NREQ-1:0] req_data;
    logic               LRFD, LDAV, wd_err;
    logic [WW-1:0]      DATA;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_src
        assign req[gi]               = s_req[gi];
        assign req_ldav[gi]          = s_ldav[gi];
        assign req_last[gi]          = s_last[gi];
        assign req_data[gi*WW +: WW] = s_data[gi];
    end

    display_bus_arbiter #(.NREQ(NREQ), .WD_LIMIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_ldav(req_ldav), .req_last(req_last),
        .req_data(req_data), .req_lrfd(req_lrfd), .LRFD(LRFD), .LDAV(LDAV),
        .DATA(DATA), .grant(grant), .wd_err(wd_err)
    );

    typedef struct {
        logic [WW-1:0]   data;
        logic [NREQ-1:0] owner;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   plen_q  [NREQ][$];
    logic [WW-1:0] pword_q [NREQ][$];
    int            compared   = 0;
    int            mismatched = 0;
    int            interleave = 0;
    bit            sink_en    = 1'b1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        compared++;
        if (act !== req_v) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req_v);
        end
    endfunction

    function automatic void timeout_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got timeout expected handshake event", name);
    endfunction

    function automatic void push_exp(input logic [WW-1:0] d, input int unsigned o);
        exp_t e;
        e.data  = d;
        e.owner = NREQ'(1) << o;
        exp_q.push_back(e);
    endfunction

    // Display-side sink: accepts words with random latency and scores each one.
    initial begin
        bit   seen;
        exp_t e;
        seen = 1'b0;
        LRFD = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!sink_en || !rst_n) begin
                LRFD = 1'b0;
                seen = 1'b0;
            end else if (!LRFD && LDAV === 1'b0) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        timeout_fail("unexpected_word");
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", 32'(DATA), 32'(e.data));
                        check("word_owner", 32'(grant), 32'(e.owner));
                    end
                end
                if ($urandom_range(0, 3) != 0) begin
                    LRFD = 1'b1;
                    seen = 1'b0;
                end
            end else if (LRFD && LDAV === 1'b1) begin
                LRFD = 1'b0;
            end
        end
    end

    // Grant must be one-hot or zero and may only change owner through an all-zero cycle.
    initial begin
        logic [NREQ-1:0] prev_g;
        prev_g = '0;
        forever begin
            @(negedge clk);
            if (prev_g != '0 && grant != '0 && grant != prev_g) interleave++;
            if ($countones(grant) > 1) interleave++;
            prev_g = grant;
        end
    end

    task automatic wait_lrfd(input int unsigned i, input logic val, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            @(posedge clk); #1;
            if (req_lrfd[i] === val) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("src_lrfd_wait");
    endtask

    task automatic src_packet(input int unsigned i, input int unsigned n, input bit abandon, input bit keep);
        bit ok;
        s_req[i] = 1'b1;
        for (int unsigned w = 0; w < n; w++) begin
            wait_lrfd(i, 1'b0, ok);
            if (!ok) break;
            s_data[i] = pword_q[i].pop_front();
            s_last[i] = !abandon && (w == n - 1);
            s_ldav[i] = 1'b0;
            wait_lrfd(i, 1'b1, ok);
            s_ldav[i] = 1'b1;
            s_last[i] = 1'b0;
            if (!ok) break;
        end
        if (abandon) begin
            s_req[i] = 1'b0;
            @(posedge clk); #1;
            check("abandon_release", 32'(grant), 32'(0));
        end else if (!keep) begin
            s_req[i] = 1'b0;
        end
    endtask

    task automatic src_stream(input int unsigned i);
        int unsigned n;
        while (plen_q[i].size() > 0) begin
            n = plen_q[i].pop_front();
            src_packet(i, n, 1'b0, plen_q[i].size() > 0);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 4 * BOUND; c++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && grant == '0 && req == '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail(name);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference order: every requester with a pending packet re-requests immediately,
    // so the next owner is the first index after the last owner that still has work.
    task automatic model_round_robin();
        int unsigned last, o, woff[NREQ], pidx[NREQ];
        bit found;
        last = NREQ - 1;
        for (int unsigned i = 0; i < NREQ; i++) begin
            woff[i] = 0;
            pidx[i] = 0;
        end
        forever begin
            found = 1'b0;
            o = 0;
            for (int unsigned k = 1; k <= NREQ; k++) begin
                o = (last + k) % NREQ;
                if (pidx[o] < plen_q[o].size()) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) break;
            for (int unsigned w = 0; w < plen_q[o][pidx[o]]; w++) push_exp(pword_q[o][woff[o] + w], o);
            woff[o] += plen_q[o][pidx[o]];
            pidx[o]++;
            last = o;
        end
    endtask

    initial begin
        logic [WW-1:0] pkt0 [4];
        logic [WW-1:0] w;
        bit            ok;
        int            cyc;

        pkt0[0] = 15'h0000; pkt0[1] = 15'h3000; pkt0[2] = 15'h01F4; pkt0[3] = 15'h31F4;
        for (int unsigned i = 0; i < NREQ; i++) begin
            s_req[i] = 1'b0; s_ldav[i] = 1'b1; s_last[i] = 1'b0; s_data[i] = '0;
        end

        repeat (3) @(posedge clk); #1;
        check("rst_ldav", 32'(LDAV), 32'(1));
        check("rst_data", 32'(DATA), 32'(0));
        check("rst_lrfd", 32'(req_lrfd), 32'(2'b11));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_wd_err", 32'(wd_err), 32'(0));
        rst_n = 1'b1;

        // Single directed packet from requester 0.
        for (int k = 0; k < 4; k++) begin
            pword_q[0].push_back(pkt0[k]);
            push_exp(pkt0[k], 0);
        end
        src_packet(0, 4, 1'b0, 1'b0);
        wait_idle("single_idle");
        check("single_grant_after", 32'(grant), 32'(0));
        check("single_data_hold", 32'(DATA), 32'(15'h31F4));

        // Contention and fairness: both stream random packets from the same cycle after reset.
        pulse_reset();
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int p = 0; p < 4; p++) begin
                plen_q[i].push_back($urandom_range(1, 5));
                for (int unsigned k = 0; k < plen_q[i][p]; k++) begin
                    w = WW'($urandom);
                    pword_q[i].push_back(w);
                end
            end
        end
        model_round_robin();
        fork
            src_stream(0);
            src_stream(1);
        join
        wait_idle("stream_idle");

        // Abandon: requester 1 drops req after two words, requester 0 must follow.
        for (int k = 0; k < 2; k++) begin
            w = WW'($urandom); pword_q[1].push_back(w); push_exp(w, 1);
        end
        for (int k = 0; k < 2; k++) begin
            w = WW'($urandom); pword_q[0].push_back(w); push_exp(w, 0);
        end
        fork
            begin
                src_packet(1, 2, 1'b1, 1'b0);
                ok = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk); #1;
                    if (grant == 2'b01) begin ok = 1'b1; break; end
                end
                check("abandon_next_grant", 32'(ok), 32'(1));
            end
            begin
                repeat (3) @(posedge clk); #1;
                src_packet(0, 2, 1'b0, 1'b0);
            end
        join
        wait_idle("abandon_idle");

        // Reset while a word is presented on the display port.
        sink_en = 1'b0;
        s_req[0] = 1'b1;
        wait_lrfd(0, 1'b0, ok);
        s_data[0] = 15'h1234;
        s_ldav[0] = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (LDAV === 1'b0) begin ok = 1'b1; break; end
        end
        check("rst_xfer_ldav_low_seen", 32'(ok), 32'(1));
        rst_n = 1'b0;
        #1;
        check("rst_xfer_ldav", 32'(LDAV), 32'(1));
        check("rst_xfer_grant", 32'(grant), 32'(0));
        check("rst_xfer_lrfd", 32'(req_lrfd), 32'(2'b11));
        s_req[0] = 1'b0;
        s_ldav[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sink_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w = WW'($urandom); pword_q[0].push_back(w); push_exp(w, 0);
        end
        src_packet(0, 3, 1'b0, 1'b0);
        wait_idle("post_reset_idle");

`ifdef DISP_ARB_WATCHDOG_EN
        // Stalled word: sink never raises LRFD, the watchdog must release the bus.
        sink_en = 1'b0;
        s_req[0] = 1'b1;
        wait_lrfd(0, 1'b0, ok);
        s_data[0] = 15'h0555;
        s_ldav[0] = 1'b0;
        cyc = 0;
        ok = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (wd_err === 1'b1) begin ok = 1'b1; cyc = c; break; end
        end
        s_req[0] = 1'b0;
        s_ldav[0] = 1'b1;
        check("wd_fired", 32'(ok), 32'(1));
        check("wd_window", 32'(cyc >= 16 && cyc <= 19), 32'(1));
        check("wd_grant_released", 32'(grant), 32'(0));
        @(posedge clk); #1;
        check("wd_single_pulse", 32'(wd_err), 32'(0));
        sink_en = 1'b1;
        wait_idle("wd_idle");
`else
        cyc = 0;
        check("wd_err_tied", 32'(wd_err), 32'(cyc));
`endif

        check("no_interleave", 32'(interleave), 32'(0));
        check("all_words_seen", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/display_bus_arbiter.md
DISPLAY_BUS_ARBITER -- requirements
Module: display_bus_arbiter

Interface
REQ-001 Parameter: NREQ, 2, number of requesters (2..4).
REQ-002 Parameter: WD_LIMIT, 65535, watchdog stall limit in clk cycles (used only with DISP_ARB_WATCHDOG_EN).
REQ-003 Port: clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req  in  NREQ  per-requester request, held high for a whole packet.
REQ-006 Port: req_ldav  in  NREQ  per-requester data-available, active-low.
REQ-007 Port: req_last  in  NREQ  per-requester flag; the word carrying it ends the packet.
REQ-008 Port: req_data  in  15*NREQ  per-requester data word; requester i occupies bits [15i+14:15i].
REQ-009 Port: req_lrfd  out  NREQ  per-requester ready-for-data; low = ready, high = word accepted.
REQ-010 Port: LRFD  in  1  display ready-for-data, same polarity as req_lrfd.
REQ-011 Port: LDAV  out  1  display data-available, active-low.
REQ-012 Port: DATA  out  15  display data word.
REQ-013 Port: grant  out  NREQ  one-hot owner; all-zero when idle.
REQ-014 Port: wd_err  out  1  one-cycle pulse on watchdog release; constant 0 without the macro.

Function
REQ-015 Word handshake per port: the sink drives LRFD low; the source drives LDAV low with DATA stable; the sink raises LRFD (accept); the source returns LDAV high.
REQ-016 FSM states: IDLE, ARB, XFER, DONE.
REQ-017 IDLE->ARB when any req is high. IDLE SHALL hold all req_lrfd high, LDAV high and grant 0.
REQ-018 ARB: one cycle. Select by round-robin, starting at the index after the last owner. After reset the last owner SHALL be NREQ-1, so index 0 wins first. Register grant, then go to XFER.
REQ-019 XFER routing: req_lrfd[g] SHALL equal LRFD registered one cycle. Every other req_lrfd SHALL be high.
REQ-020 XFER routing: LDAV SHALL equal req_ldav[g] registered one cycle. DATA SHALL equal the req_data slice of g registered one cycle.
REQ-021 A word is accepted on the cycle where the registered LDAV is low and LRFD is high. The arbiter SHALL capture req_last[g] on that cycle.
REQ-022 XFER->DONE when the captured last is set and req_ldav[g] returns high.
REQ-023 XFER->DONE when req[g] falls while req_ldav[g] is high (abandoned packet).
REQ-024 DONE: LDAV high, grant cleared, last owner updated. DONE->IDLE, or DONE->ARB if any req is high.
REQ-025 A packet SHALL never interleave with another. Grant SHALL change only through DONE.
REQ-026 If req[g] falls while req_ldav[g] is low, the arbiter SHALL finish that word before leaving XFER.
REQ-027 A lone requester SHALL win every arbitration. Minimum gap between packets is 2 cycles (DONE, ARB).

Reset
REQ-028 While rst_n is low: state IDLE, LDAV 1, DATA 0, req_lrfd all 1, grant 0, wd_err 0, last owner NREQ-1, watchdog counter 0.
REQ-029 Reset asserted mid-XFER SHALL force LDAV high within the same asynchronous assertion. No partial word survives reset.

Configuration
REQ-030 With DISP_ARB_WATCHDOG_EN defined, a counter SHALL count XFER cycles with no LRFD or req_ldav[g] edge. It resets on any such edge.
REQ-031 When that counter reaches WD_LIMIT, the FSM SHALL go to DONE, force LDAV high and pulse wd_err for 1 cycle.
REQ-032 Without DISP_ARB_WATCHDOG_EN there SHALL be no counter logic, wd_err SHALL be tied 0, and XFER waits indefinitely.

Structure
REQ-033 Shared package disp_pkg SHALL hold: the 15-bit word width, the opcode field values 4'b0000 / 4'b0010 / 4'b0011 (x / y-move / y-draw), and the arbiter FSM state enum.
REQ-034 Round-robin selection SHALL be a sub-module, rr_pick: inputs req and last owner; output a one-hot grant; purely combinational.

Verification
REQ-035 Single packet: requester 0 sends 0x0000, 0x1000|0x2000, 0x01F4, last 0x31F4. Required: DATA shows the 4 words in order, grant=01 throughout, then grant=00.
REQ-036 Contention: req=11 asserted on the same cycle after reset. Required: grant=01 first, then 10, with no interleaving of DATA.
REQ-037 Fairness: both requesters stream continuously. Required: grants alternate 01,10,01,10 over 8 packets.
REQ-038 Abandon: requester 1 drops req after 2 words with req_ldav high. Required: DONE within 1 cycle, then requester 0 is granted.
REQ-039 Reset in XFER with LDAV low: assert rst_n=0. Required: LDAV=1, grant=0 immediately, and the next packet starts cleanly.
REQ-040 With the macro and WD_LIMIT=16: LRFD is held low for 20 cycles during a word. Required: wd_err pulses at cycle 16 and grant releases.
